// File: rtl/weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// weight_fetch_ctrl
//
// Streams a run of binarized weight words from a synchronous weight ROM to
// the PE array. A pass is requested with a one-cycle start pulse carrying the
// first ROM address and the word count. Reads are issued back to back, and
// each returned word lands in a 2-entry output FIFO that feeds a
// valid/ready interface toward the PE array. Back-pressure is absorbed by
// the FIFO. A read is only issued when it is certain to have a free slot
// when its data returns.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pass request (honoured only in IDLE)
//   base_addr  in   [ADDR_WIDTH-1:0] first ROM address of the pass
//   num_words  in   [ADDR_WIDTH:0]   word count, 0..2^ADDR_WIDTH
//   rom_en     out  ROM read enable
//   rom_addr   out  [ADDR_WIDTH-1:0] ROM read address
//   rom_data   in   [DATA_WIDTH-1:0] registered ROM output, valid the cycle
//                   after rom_en
//   w_valid    out  weight word valid toward the PE array
//   w_ready    in   PE array accept
//   w_data     out  [DATA_WIDTH-1:0] weight word (FIFO head)
//   w_last     out  head is the final word of the pass
//   busy       out  pass in progress (low in IDLE and FIN)
//   done       out  one-cycle pulse at pass completion
// ---------------------------------------------------------------------------
module weight_fetch_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state;

    logic [ADDR_WIDTH:0]   reads_left;     // reads still to issue this pass
    logic                  in_flight;      // a read was issued last cycle
    logic                  in_flight_last; // ... and it was the final word

    // 2-entry output FIFO
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  push;
    logic                  pop;
    logic                  last_read;
    logic [2:0]            occupancy;

    // The returning read is written unconditionally; there is always room
    // because a read is only issued when occupancy leaves a free slot.
    assign push      = in_flight;
    assign w_valid   = (count != 2'd0);
    assign pop       = w_valid && w_ready;
    assign w_data    = fifo_data[rd_ptr];
    // Slot flags can be stale once drained, so qualify with w_valid.
    assign w_last    = w_valid && fifo_last[rd_ptr];
    assign last_read = (reads_left == {{ADDR_WIDTH{1'b0}}, 1'b1});

    // Slots already committed next cycle: buffered words plus the word in
    // flight, minus the one leaving now. Pop implies count >= 1, so no wrap.
    assign occupancy = ({1'b0, count} + {2'b00, in_flight}) - {2'b00, pop};

    // Combinational because it must see this cycle's pop (w_ready) to keep
    // one word per cycle under full throughput.
    assign rom_en    = (state == FETCH) && (reads_left != '0) && (occupancy < 3'd2);

    // NOTE: every register here is assigned with <= so all updates in this
    // block see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rom_addr       <= '0;
            reads_left     <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            // NOTE: the FIFO storage is reset too, so w_data reads 0 out of
            // reset; a 2-word array costs little to clear, unlike a real RAM.
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last      <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            count          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;

            // Read issue and address walk; the address wraps naturally.
            in_flight      <= rom_en;
            in_flight_last <= rom_en && last_read;
            if (rom_en) begin
                rom_addr   <= rom_addr + 1'b1;
                reads_left <= reads_left - 1'b1;
            end

            // FIFO write/pop; both together leave count unchanged.
            if (push) begin
                fifo_data[wr_ptr] <= rom_data;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr   <= base_addr;
                        reads_left <= num_words;
                        if (num_words == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (rom_en && last_read) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && w_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weight_fetch_ctrl
//
// Self-checking bench for weight_fetch_ctrl. A behavioural registered ROM
// answers reads with a function of the address. Expected ROM addresses and
// expected (data, last) words are queued when a pass is started and popped
// by a negedge monitor as the DUT issues reads and hands words over.
// Directed loops check cycle-exact timing, back-pressure, zero-length
// passes, ignored starts and mid-pass reset.
// ---------------------------------------------------------------------------
module tb_weight_fetch_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          w_last;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] addr_q [$];
    word_t         data_q [$];

    weight_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'd3};
    endfunction

    // Registered ROM: data valid the cycle after rom_en.
    initial rom_data = '0;
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_f(rom_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_en) begin
                if (addr_q.size() == 0) check("rom_en_unexpected", 1, 0);
                else check("rom_addr", rom_addr, addr_q.pop_front());
            end
            if (w_valid && w_ready) begin
                if (data_q.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    word_t e;
                    e = data_q.pop_front();
                    check("w_data", w_data, e.data);
                    check("w_last", w_last, e.last);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after edge E (cycle E+1).
    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] nw);
        logic [AW-1:0] a;
        word_t         w;
        start     = 1'b1;
        base_addr = base;
        num_words = nw;
        for (int k = 0; k < int'(nw); k++) begin
            a = base + AW'(k);
            addr_q.push_back(a);
            w.data = rom_f(a);
            w.last = (k == int'(nw) - 1);
            data_q.push_back(w);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (rnd) w_ready = 1'($urandom_range(0, 1));
            end
        end
        check("done_seen", seen, 1);
        @(posedge clk);
        #1;
        w_ready = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rom_en"},   rom_en,   0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_w_valid"},  w_valid,  0);
        check({tag, "_w_data"},   w_data,   0);
        check({tag, "_w_last"},   w_last,   0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        w_ready   = 1'b1;

        // Reset state
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A: base 0x10, 4 words, w_ready high: exact cycle timing
        do_start(8'h10, 9'd4);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("A_rom_en[%0d]", n),  rom_en,  (n <= 4));
            check($sformatf("A_w_valid[%0d]", n), w_valid, (n >= 3 && n <= 6));
            check($sformatf("A_w_last[%0d]", n),  w_last,  (n == 6));
            check($sformatf("A_done[%0d]", n),    done,    (n == 7));
            check($sformatf("A_busy[%0d]", n),    busy,    (n <= 6));
            @(posedge clk);
            #1;
        end
        check("A_sb_empty", data_q.size(), 0);

        // B: address wrap 0xFE, 0xFF, 0x00
        do_start(8'hFE, 9'd3);
        wait_done(1'b0);
        check("B_sb_empty", data_q.size() + addr_q.size(), 0);

        // C: back-pressure for cycles E+3..E+8
        do_start(8'h40, 9'd4);
        for (int n = 1; n <= 10; n++) begin
            w_ready = !(n >= 3 && n <= 8);
            @(negedge clk);
            if (n >= 3 && n <= 8) begin
                check($sformatf("C_rom_en_full[%0d]", n), rom_en,  0);
                check($sformatf("C_w_valid[%0d]", n),     w_valid, 1);
                check($sformatf("C_w_data_hold[%0d]", n), w_data,  rom_f(8'h40));
                check($sformatf("C_w_last[%0d]", n),      w_last,  0);
            end
            @(posedge clk);
            #1;
        end
        wait_done(1'b0);
        check("C_sb_empty", data_q.size(), 0);

        // D: zero-length pass
        do_start(8'h55, 9'd0);
        @(negedge clk);
        check("D_done",    done,    1);
        check("D_rom_en",  rom_en,  0);
        check("D_w_valid", w_valid, 0);
        check("D_busy",    busy,    0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("D_done_clr", done, 0);
        @(posedge clk);
        #1;

        // E: start re-asserted while busy is ignored
        do_start(8'h20, 9'd3);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 8'h80;
        num_words = 9'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0);
        check("E_sb_empty", data_q.size() + addr_q.size(), 0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("E_idle", {rom_en, w_valid, busy, done}, 0);
            @(posedge clk);
            #1;
        end

        // F: reset in cycle E+4 of an 8-word pass
        do_start(8'h00, 9'd8);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("F_async");
        addr_q.delete();
        data_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("F_idle", {rom_en, w_valid, busy, done}, 0);
        end
        @(posedge clk);
        #1;

        // G: fresh pass after reset with random back-pressure
        do_start(8'h33, 9'd5);
        wait_done(1'b1);
        check("G_sb_empty", data_q.size() + addr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
